// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared FSM encoding and write-back mux select constants
package wb_port_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;
    localparam logic WB_SEL_PIPE = 1'b0;
    localparam logic WB_SEL_MC   = 1'b1;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: small synchronous FIFO holding {rd, data} multi-cycle results
module wb_result_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    parameter int NW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  data,
    output logic          full,
    output logic          empty,
    output logic [NW-1:0] count,
    output logic [W-1:0]  head
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_push, do_pop;
    always_comb begin
        full = count == NW'(DEPTH);
        empty = count == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        head = mem[rp];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wp] <= data;
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= do_pop ? rp + 1'b1 : rp;
            count <= count + NW'(do_push) - NW'(do_pop);
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline and multi-cycle results
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pipe_valid,
    input  logic [AW-1:0] pipe_rd,
    input  logic          mc_valid,
    input  logic [AW-1:0] mc_rd,
    input  logic [DW-1:0] mc_data,
    output logic          mc_ready,
    output logic [DW-1:0] mc_head_data,
    output logic          wb_sel,
    output logic          wb_we,
    output logic [AW-1:0] wb_rd,
    output logic          pipe_stall
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int NW = $clog2(DEPTH) + 1;
    state_t state;
    logic [CW-1:0] wait_cnt;
    logic full, empty, push, pop, last;
    logic [NW-1:0] count;
    logic [DW+AW-1:0] head;
    wb_result_fifo #(.W(DW + AW), .DEPTH(DEPTH), .NW(NW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .data({mc_rd, mc_data}),
        .full(full),
        .empty(empty),
        .count(count),
        .head(head)
    );
    always_comb begin
        mc_ready = !rst && !full;
        push = mc_valid && mc_ready;
        wb_sel = (!rst && !empty && (state == DRAIN || (state == PEND && !pipe_valid))) ? WB_SEL_MC : WB_SEL_PIPE;
        pop = wb_sel == WB_SEL_MC;
        pipe_stall = !rst && state == DRAIN;
        wb_rd = rst ? '0 : (wb_sel == WB_SEL_MC) ? head[DW+AW-1:DW] : pipe_rd;
        wb_we = (pop || pipe_valid) && wb_rd != '0;
        last = count == NW'(1) && !push;
        mc_head_data = head[DW-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wait_cnt <= '0;
        end else begin
            state <= (state == IDLE) ? (push ? PEND : IDLE) :
                     (state == PEND && !pop) ? ((wait_cnt == CW'(MAX_WAIT - 1)) ? DRAIN : PEND) :
                     (last ? IDLE : PEND);
            wait_cnt <= (state == PEND && !pop) ? wait_cnt + 1'b1 : '0;
        end
    end
endmodule
